vscpu_mem_responder: RTL and testbench
======================================

// Module: vscpu_mem_responder
// PURPOSE
//  Memory-side responder on the VSCPU RAM port (wrEn/addr_toRAM/data_toRAM -> data_fromRAM).
//  Word-addressed synchronous RAM plus a 4-word MMIO window at the top of the address space.
//  MMIO window: output FIFO drained by a valid/ready port, status register, cycle counter.
//  Drop-in replacement for blram on the CPU side, with observable output for benches and SoC glue.
// PARAMETERS
//  SIZE        14     address width in words
//  DEPTH       2**SIZE  address space in words; RAM stores words 0..DEPTH-5
//  FIFO_DEPTH  8      output FIFO entries, power of two, >= 2
// PORTS
//  clk           in   1      rising-edge clock
//  rst           in   1      asynchronous, active-low reset
//  wrEn          in   1      write strobe from CPU, sampled on clk rising edge
//  addr_toRAM    in   SIZE   word address from CPU
//  data_toRAM    in   32     write data from CPU
//  data_fromRAM  out  32     read data, registered
//  out_data      out  32     FIFO head word
//  out_valid     out  1      FIFO not empty
//  out_ready     in   1      consumer accepts head; pop when out_valid & out_ready
//  fifo_full     out  1      FIFO holds FIFO_DEPTH entries
// BEHAVIOUR
//  Reset (rst=0, async): data_fromRAM=0, out_valid=0, fifo_full=0, count/pointers=0,
//   cycle counter=0, overflow=0. RAM array 'mem' is NOT cleared (benches preload it hierarchically).
//  Read: every cycle data_fromRAM <= word at addr_toRAM; latency 1 clk, no handshake. Reads happen regardless of wrEn.
//  Write: wrEn=1 stores data_toRAM at addr_toRAM at the clock edge.
//  MMIO map (A=DEPTH):
//   A-4 OUT: write pushes data_toRAM into FIFO; read returns {.., count} zero-extended.
//   A-3 STATUS: read {29'b0, overflow, full, empty}; any write clears overflow.
//   A-2 CYCLE: read free-running 32-bit counter (+1 every clk, wraps 0xFFFFFFFF->0); write loads 0.
//   A-1 reserved: reads 0, writes ignored.
//  MMIO reads also 1-clk latency; read value is state BEFORE the same-edge update.
//  FIFO: push on OUT write; pop on out_valid&out_ready; out_data = head (first-word fall-through).
//   Push when full and no same-cycle pop: word dropped, overflow set (sticky).
//   Push+pop same cycle: count unchanged (legal when full: pop frees slot).
//   Pop when empty: ignored. Pointers wrap modulo FIFO_DEPTH.
//  Read-during-write to same RAM address: see CONFIGURATION.
//  Reset mid-operation: FIFO contents discarded, in-flight read result lost; data_fromRAM=0 next.
// CONFIGURATION
//  VSCPU_MEM_WR_BYPASS_EN defined: same-cycle RAM read+write to one address returns data_toRAM.
//  Undefined: returns the old stored word (read-before-write). MMIO unaffected either way.
// STRUCTURE
//  Package vscpu_mem_pkg: MMIO offset constants (OFS_OUT=4, OFS_STATUS=3, OFS_CYCLE=2,
//   OFS_RSVD=1), STATUS bit indices (ST_EMPTY=0, ST_FULL=1, ST_OVF=2), word typedef word_t.
//  Sub-module vscpu_out_fifo (FIFO_DEPTH, push/pop/full/empty/count); decode + RAM + counter in top.
// TESTING
//  Preload mem[100]=5, hold addr=100 -> data_fromRAM=5 exactly one clk later; 0 during reset.
//  wrEn, addr=101, data=0xA then addr=101 read -> 0xA; same-cycle rd/wr addr 101 data 0x3D ->
//   0x3D with VSCPU_MEM_WR_BYPASS_EN, 0xA without.
//  out_ready=0, write 0x11..0x18 to A-4 -> fifo_full=1, STATUS=0x2; 9th write 0x19 -> STATUS=0x6,
//   drain with out_ready=1 yields 0x11..0x18 in order, then out_valid=0, STATUS=0x5.
//  Full FIFO, push 0x20 with out_ready=1 same cycle -> count stays 8, no overflow, 0x20 last out.
//  Write A-2 at cycle k, read A-2 3 clks later -> 3; STATUS write clears overflow to 0.
//  Assert rst low while 3 words queued -> out_valid=0, data_fromRAM=0 immediately; mem[100] still 5.

Source files
------------

// File: rtl/vscpu_mem_pkg.sv
// rtl/vscpu_mem_pkg.sv - shared types and MMIO constants for the VSCPU memory responder
// Purpose : word type, MMIO offsets measured down from the top of the address
//           space, STATUS bit positions and a helper that assembles STATUS.
// Ports   : none (package)
package vscpu_mem_pkg;

   typedef logic [31:0] word_t;

   // MMIO registers sit at DEPTH - OFS_*
   localparam int OFS_OUT    = 4;
   localparam int OFS_STATUS = 3;
   localparam int OFS_CYCLE  = 2;
   localparam int OFS_RSVD   = 1;

   // STATUS register bit positions
   localparam int ST_EMPTY = 0;
   localparam int ST_FULL  = 1;
   localparam int ST_OVF   = 2;

   function automatic word_t statusWord(input logic ovf, input logic full, input logic empty);
      word_t w;
      w = '0;
      w[ST_OVF]   = ovf;
      w[ST_FULL]  = full;
      w[ST_EMPTY] = empty;
      return w;
   endfunction

endpackage

// File: rtl/vscpu_out_fifo.sv
// rtl/vscpu_out_fifo.sv - first-word fall-through output FIFO for the MMIO OUT register
// Purpose : FIFO_DEPTH-entry queue (power of two, >= 2). A push into a full
//           FIFO is dropped unless a pop happens on the same edge; a pop on an
//           empty FIFO is ignored. headData always shows the oldest entry.
// Ports   : clk, rst (async active-low), push/pushData, pop,
//           headData, full, empty, count, dropped (push refused this cycle)
import vscpu_mem_pkg::*;

module vscpu_out_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  word_t                       pushData,
   input  logic                        pop,
   output word_t                       headData,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic                        dropped
);

   localparam int PW = $clog2(FIFO_DEPTH);

   word_t         store [FIFO_DEPTH];
   logic [PW-1:0] wrPtr;
   logic [PW-1:0] rdPtr;
   logic [PW:0]   cnt;
   logic          doPush;
   logic          doPop;

   assign empty    = (cnt == '0);
   assign full     = (cnt == (PW+1)'(FIFO_DEPTH));
   assign doPop    = pop & ~empty;
   // a same-edge pop frees the slot a full FIFO needs
   assign doPush   = push & (~full | doPop);
   assign dropped  = push & ~doPush;
   assign count    = cnt;
   assign headData = store[rdPtr];

   // pointers wrap naturally because FIFO_DEPTH is a power of two
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + 1'b1;
         if (doPop)  rdPtr <= rdPtr + 1'b1;
         cnt <= cnt + (PW+1)'(doPush) - (PW+1)'(doPop);
      end
   end

   // storage is not reset; reset empties the FIFO through the pointers
   always_ff @(posedge clk) begin
      if (doPush) store[wrPtr] <= pushData;
   end

endmodule

// File: rtl/vscpu_mem_responder.sv
// rtl/vscpu_mem_responder.sv - VSCPU RAM-port responder: word RAM plus 4-word MMIO window
// Purpose : synchronous word RAM for addresses 0..DEPTH-5 and an MMIO window
//           at DEPTH-4..DEPTH-1 (OUT FIFO, STATUS, CYCLE counter, reserved).
//           Every read has one clock of latency and returns the state before
//           the same-edge update.
// Config  : VSCPU_MEM_WR_BYPASS_EN defined -> a RAM write returns the written
//           word on the same-cycle read; undefined -> the old stored word.
// Ports   : clk, rst (async active-low), wrEn, addr_toRAM, data_toRAM,
//           data_fromRAM (registered read data), out_data/out_valid/out_ready
//           (FIFO drain port), fifo_full
import vscpu_mem_pkg::*;

module vscpu_mem_responder #(
   parameter int SIZE       = 14,
   parameter int FIFO_DEPTH = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wrEn,
   input  logic [SIZE-1:0] addr_toRAM,
   input  word_t           data_toRAM,
   output word_t           data_fromRAM,
   output word_t           out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            fifo_full
);

   localparam int DEPTH     = 2**SIZE;
   localparam int RAM_WORDS = DEPTH - 4;
   localparam int CW        = $clog2(FIFO_DEPTH) + 1;

   // left uncleared by reset so benches can preload it hierarchically
   word_t mem [RAM_WORDS];

   logic          isMmio;
   logic [SIZE:0] topDist;
   logic          wrOut;
   logic          wrStatus;
   logic          wrCycle;
   word_t         ramWord;
   word_t         rdNext;
   word_t         cycleCnt;
   logic          overflow;
   logic          fifoEmpty;
   logic          fifoFull;
   logic          fifoDropped;
   logic [CW-1:0] fifoCount;

   assign isMmio   = (addr_toRAM >= SIZE'(RAM_WORDS));
   // distance from the top of the address space selects the MMIO register
   assign topDist  = (SIZE+1)'(DEPTH) - {1'b0, addr_toRAM};
   assign wrOut    = wrEn & isMmio & (topDist == (SIZE+1)'(OFS_OUT));
   assign wrStatus = wrEn & isMmio & (topDist == (SIZE+1)'(OFS_STATUS));
   assign wrCycle  = wrEn & isMmio & (topDist == (SIZE+1)'(OFS_CYCLE));

   vscpu_out_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (wrOut),
      .pushData (data_toRAM),
      .pop      (out_ready),
      .headData (out_data),
      .full     (fifoFull),
      .empty    (fifoEmpty),
      .count    (fifoCount),
      .dropped  (fifoDropped)
   );

   assign out_valid = ~fifoEmpty;
   assign fifo_full = fifoFull;

   // single address port: a write always targets the word being read
   always_comb begin
      ramWord = mem[addr_toRAM];
`ifdef VSCPU_MEM_WR_BYPASS_EN
      if (wrEn) ramWord = data_toRAM;
`endif
   end

   always_comb begin
      rdNext = ramWord;
      if (isMmio) begin
         case (topDist)
            (SIZE+1)'(OFS_OUT):    rdNext = word_t'(fifoCount);
            (SIZE+1)'(OFS_STATUS): rdNext = statusWord(overflow, fifoFull, fifoEmpty);
            (SIZE+1)'(OFS_CYCLE):  rdNext = cycleCnt;
            default:               rdNext = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn && !isMmio) mem[addr_toRAM] <= data_toRAM;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_fromRAM <= '0;
         cycleCnt     <= '0;
         overflow     <= 1'b0;
      end else begin
         data_fromRAM <= rdNext;
         cycleCnt     <= wrCycle ? '0 : cycleCnt + 32'd1;
         // STATUS write and OUT push never coincide (one address per cycle)
         if (wrStatus)         overflow <= 1'b0;
         else if (fifoDropped) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vscpu_mem_responder.sv
// tb/tb_vscpu_mem_responder.sv - self-checking bench for vscpu_mem_responder
import vscpu_mem_pkg::*;

module tb_vscpu_mem_responder;

   localparam int SIZE  = 14;
   localparam int FD    = 8;
   localparam int DEPTH = 2**SIZE;
   localparam int A_OUT = DEPTH - 4;
   localparam int A_ST  = DEPTH - 3;
   localparam int A_CYC = DEPTH - 2;
   localparam int A_RSV = DEPTH - 1;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            wrEn = 1'b0;
   logic [SIZE-1:0] addr_toRAM = '0;
   word_t           data_toRAM = '0;
   word_t           data_fromRAM;
   word_t           out_data;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic            fifo_full;

   always #5 clk = ~clk;

   vscpu_mem_responder #(.SIZE(SIZE), .FIFO_DEPTH(FD)) dut (
      .clk          (clk),
      .rst          (rst),
      .wrEn         (wrEn),
      .addr_toRAM   (addr_toRAM),
      .data_toRAM   (data_toRAM),
      .data_fromRAM (data_fromRAM),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fifo_full    (fifo_full)
   );

   int passCount = 0;
   int failCount = 0;
   int totalCount = 0;

   // reference model: sparse RAM, FIFO queue, sticky overflow, cycle count
   word_t ramModel [int];
   word_t fifoQ [$];
   bit    ovfModel = 0;
   word_t cycModel = '0;

   task automatic check(input string tag, input word_t obs, input word_t exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else begin
         failCount++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      fifoQ.delete();
      ovfModel = 0;
      cycModel = '0;
   endtask

   // one clock: drive inputs, predict from the model, then compare after the edge
   task automatic cyc(input bit we, input int a, input word_t d, input bit rdy, input string tag);
      word_t expRd;
      bit    known;
      bit    doPop;
      bit    push;
      bit    drop;
      known = 1;
      expRd = '0;
      if (a >= A_OUT) begin
         if (a == A_OUT)      expRd = word_t'(fifoQ.size());
         else if (a == A_ST)  expRd = {29'd0, ovfModel, fifoQ.size() == FD, fifoQ.size() == 0};
         else if (a == A_CYC) expRd = cycModel;
         else                 expRd = '0;
      end else begin
`ifdef VSCPU_MEM_WR_BYPASS_EN
         if (we) expRd = d;
         else begin
            known = ramModel.exists(a) != 0;
            if (known) expRd = ramModel[a];
         end
`else
         known = ramModel.exists(a) != 0;
         if (known) expRd = ramModel[a];
`endif
      end
      doPop = rdy && fifoQ.size() > 0;
      push  = we && a == A_OUT;
      drop  = push && fifoQ.size() == FD && !doPop;
      if (drop) ovfModel = 1;
      if (doPop) void'(fifoQ.pop_front());
      if (push && !drop) fifoQ.push_back(d);
      if (we && a == A_ST) ovfModel = 0;
      if (we && a == A_CYC) cycModel = '0;
      else cycModel = cycModel + 32'd1;
      if (we && a < A_OUT) ramModel[a] = d;

      wrEn       = we;
      addr_toRAM = SIZE'(a);
      data_toRAM = d;
      out_ready  = rdy;
      @(posedge clk);
      #1;
      if (known) check({tag, ".rd"}, data_fromRAM, expRd);
      check({tag, ".valid"}, word_t'(out_valid), word_t'(fifoQ.size() > 0));
      check({tag, ".full"}, word_t'(fifo_full), word_t'(fifoQ.size() == FD));
      if (fifoQ.size() > 0) check({tag, ".head"}, out_data, fifoQ[0]);
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst.rd", data_fromRAM, 32'd0);
      check("rst.valid", word_t'(out_valid), 32'd0);
      check("rst.full", word_t'(fifo_full), 32'd0);
      dut.mem[100] = 32'd5;
      ramModel[100] = 32'd5;
      modelReset();
      rst = 1'b1;
      #1;
      check("rel.rd0", data_fromRAM, 32'd0);

      // RAM read latency, write then read, same-cycle read/write
      cyc(0, 100, 32'd0, 0, "rd100");
      check("rd100.lit", data_fromRAM, 32'd5);
      cyc(1, 101, 32'hA, 0, "wr101");
      cyc(0, 101, 32'd0, 0, "rd101");
      check("rd101.lit", data_fromRAM, 32'hA);
      cyc(1, 101, 32'h3D, 0, "rdwr101");
`ifdef VSCPU_MEM_WR_BYPASS_EN
      check("rdwr101.lit", data_fromRAM, 32'h3D);
`else
      check("rdwr101.lit", data_fromRAM, 32'hA);
`endif
      cyc(0, 101, 32'd0, 0, "rd101b");
      check("rd101b.lit", data_fromRAM, 32'h3D);

      // fill FIFO, overflow, drain in order
      for (int i = 0; i < FD; i++) cyc(1, A_OUT, word_t'(32'h11 + i), 0, "fill");
      check("fill.full", word_t'(fifo_full), 32'd1);
      cyc(0, A_ST, 32'd0, 0, "st.full");
      check("st.full.lit", data_fromRAM, 32'h2);
      cyc(1, A_OUT, 32'h19, 0, "push9");
      cyc(0, A_ST, 32'd0, 0, "st.ovf");
      check("st.ovf.lit", data_fromRAM, 32'h6);
      for (int i = 0; i < FD; i++) begin
         check("drain.lit", out_data, word_t'(32'h11 + i));
         cyc(0, 100, 32'd0, 1, "drain");
      end
      check("drain.empty", word_t'(out_valid), 32'd0);
      cyc(0, A_ST, 32'd0, 1, "st.empty");
      check("st.empty.lit", data_fromRAM, 32'h5);
      cyc(1, A_ST, 32'd0, 0, "st.clr");
      cyc(0, A_ST, 32'd0, 0, "st.clrd");
      check("st.clrd.lit", data_fromRAM, 32'h1);

      // push and pop on the same edge while full
      for (int i = 0; i < FD; i++) cyc(1, A_OUT, word_t'(32'h11 + i), 0, "fill2");
      cyc(1, A_OUT, 32'h20, 1, "pushpop");
      cyc(0, A_OUT, 32'd0, 0, "cnt8");
      check("cnt8.lit", data_fromRAM, 32'd8);
      cyc(0, A_ST, 32'd0, 0, "st.noovf");
      check("st.noovf.lit", data_fromRAM, 32'h2);
      while (fifoQ.size() > 1) cyc(0, 100, 32'd0, 1, "drain2");
      check("last.lit", out_data, 32'h20);
      cyc(0, 100, 32'd0, 1, "drain2z");

      // cycle counter load then read back
      cyc(1, A_CYC, 32'hFFFF, 0, "cyc.ld");
      for (int i = 0; i < 3; i++) cyc(0, 100, 32'd0, 0, "cyc.idle");
      cyc(0, A_CYC, 32'd0, 0, "cyc.rd");
      check("cyc.rd.lit", data_fromRAM, 32'd3);
      cyc(1, A_RSV, 32'hDEAD, 0, "rsv.wr");
      cyc(0, A_RSV, 32'd0, 0, "rsv.rd");
      check("rsv.rd.lit", data_fromRAM, 32'd0);

      // randomized mix against the model
      for (int n = 0; n < 300; n++) begin
         int    kind;
         int    a;
         bit    we;
         word_t d;
         kind = int'($urandom_range(0, 9));
         we   = $urandom_range(0, 1) == 1;
         d    = $urandom;
         if (kind < 5)       a = int'($urandom_range(200, 231));
         else if (kind < 7) begin a = A_OUT; we = $urandom_range(0, 3) != 0; end
         else if (kind == 7) begin a = A_ST; we = $urandom_range(0, 3) == 0; end
         else if (kind == 8) begin a = A_CYC; we = $urandom_range(0, 3) == 0; end
         else                a = A_RSV;
         cyc(we, a, d, $urandom_range(0, 2) == 0, "rand");
      end

      // asynchronous reset with words queued
      for (int i = 0; i < FD + 1; i++) cyc(0, 100, 32'd0, 1, "flush");
      for (int i = 0; i < 3; i++) cyc(1, A_OUT, word_t'(32'h40 + i), 0, "q3");
      cyc(0, 100, 32'd0, 0, "q3.rd");
      #2;
      rst = 1'b0;
      modelReset();
      #1;
      check("arst.valid", word_t'(out_valid), 32'd0);
      check("arst.rd", data_fromRAM, 32'd0);
      check("arst.full", word_t'(fifo_full), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc(0, 100, 32'd0, 0, "post.rd100");
      check("post.rd100.lit", data_fromRAM, 32'd5);
      cyc(0, A_ST, 32'd0, 0, "post.st");
      check("post.st.lit", data_fromRAM, 32'h1);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
